// File: rtl/ibr128_msg_sequencer.sv
// Frames a valid/ready block stream into IBR128_core: one Enable pulse per block, OB low for the message.
// Define IBR128_SEQ_TIMEOUT_EN to add a RUN watchdog that sets sticky err_o and aborts the message.
module ibr128_msg_sequencer #(
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         cfg_sa_i,
    input  logic         cfg_encrypt_i,
    input  logic [1:0]   cfg_som_i,
    input  logic [31:0]  cfg_iv_i,
    input  logic [63:0]  cfg_key0_i,
    input  logic [63:0]  cfg_key1_i,
    input  logic         abort_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [127:0] in_data_i,
    input  logic         in_last_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [127:0] out_data_o,
    output logic         out_last_o,
    output logic         core_enable_o,
    output logic         core_ob_o,
    output logic         core_sa_o,
    output logic         core_encrypt_o,
    output logic [1:0]   core_som_o,
    output logic [31:0]  core_iv_o,
    output logic [63:0]  core_key0_o,
    output logic [63:0]  core_key1_o,
    output logic [127:0] core_plaintext_o,
    input  logic [127:0] core_ciphertext_i,
    input  logic         core_cipher_ready_i,
    output logic         busy_o,
    output logic [15:0]  blk_cnt_o,
    output logic         err_o
);
    typedef enum logic [2:0] {IDLE, RUN, HOLD, GAP, NEXT} state_e;

    localparam logic [15:0] GAP_LIM = 16'(GAP_CYCLES);

    if (GAP_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("ibr128_msg_sequencer: GAP_CYCLES and TIMEOUT_CYCLES must be >= 1");
    end

    state_e         state_q;
    logic           enable_q, ob_q, in_ready_q, out_valid_q, out_last_q;
    logic           last_q, run_first_q;
    logic [127:0]   out_data_q, plain_q;
    logic [15:0]    blk_cnt_q, gap_cnt_q;
    logic           sa_q, enc_q;
    logic [1:0]     som_q;
    logic [31:0]    iv_q;
    logic [63:0]    key0_q, key1_q;

    logic in_hs, out_hs, rdy_ok, tmo_hit, kill;

    assign in_hs  = in_valid_i & in_ready_q;
    assign out_hs = out_valid_q & out_ready_i;
    // Ready in the first RUN cycle may be left over from the previous block.
    assign rdy_ok = core_cipher_ready_i & ~run_first_q;
    assign kill   = (state_q != IDLE) &
                    (abort_i | ((state_q == RUN) & tmo_hit & ~rdy_ok));

`ifdef IBR128_SEQ_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] tmo_cnt_q;
    logic        err_q;

    assign tmo_hit = (tmo_cnt_q == TMO_LAST);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            tmo_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            tmo_cnt_q <= (state_q == RUN) ? tmo_cnt_q + 16'd1 : 16'd0;
            if (state_q == RUN && !abort_i && !rdy_ok && tmo_hit)
                err_q <= 1'b1;
        end
    end

    assign err_o = err_q;
`else
    assign tmo_hit = 1'b0;
    assign err_o   = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= IDLE;
            enable_q    <= 1'b0;
            ob_q        <= 1'b1;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
            last_q      <= 1'b0;
            run_first_q <= 1'b0;
            plain_q     <= '0;
            blk_cnt_q   <= '0;
            gap_cnt_q   <= '0;
            sa_q        <= 1'b0;
            enc_q       <= 1'b0;
            som_q       <= '0;
            iv_q        <= '0;
            key0_q      <= '0;
            key1_q      <= '0;
        end else if (kill) begin
            state_q     <= IDLE;
            enable_q    <= 1'b0;
            ob_q        <= 1'b1;
            out_valid_q <= 1'b0;
            blk_cnt_q   <= '0;
            in_ready_q  <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_hs) begin
                        plain_q     <= in_data_i;
                        last_q      <= in_last_i;
                        sa_q        <= cfg_sa_i;
                        enc_q       <= cfg_encrypt_i;
                        som_q       <= cfg_som_i;
                        iv_q        <= cfg_iv_i;
                        key0_q      <= cfg_key0_i;
                        key1_q      <= cfg_key1_i;
                        enable_q    <= 1'b1;
                        ob_q        <= 1'b0;
                        in_ready_q  <= 1'b0;
                        run_first_q <= 1'b1;
                        state_q     <= RUN;
                    end else begin
                        in_ready_q  <= 1'b1;
                    end
                end
                RUN: begin
                    run_first_q <= 1'b0;
                    if (rdy_ok) begin
                        out_data_q  <= core_ciphertext_i;
                        out_valid_q <= 1'b1;
                        out_last_q  <= last_q;
                        blk_cnt_q   <= blk_cnt_q + 16'd1;
                        enable_q    <= 1'b0;
                        gap_cnt_q   <= 16'd1;
                        state_q     <= HOLD;
                    end
                end
                HOLD: begin
                    if (gap_cnt_q != 16'hFFFF) gap_cnt_q <= gap_cnt_q + 16'd1;
                    if (out_hs) begin
                        out_valid_q <= 1'b0;
                        if (last_q) begin
                            ob_q       <= 1'b1;
                            blk_cnt_q  <= '0;
                            in_ready_q <= 1'b1;
                            state_q    <= IDLE;
                        end else if (gap_cnt_q >= GAP_LIM) begin
                            in_ready_q <= 1'b1;
                            state_q    <= NEXT;
                        end else begin
                            state_q    <= GAP;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt_q != 16'hFFFF) gap_cnt_q <= gap_cnt_q + 16'd1;
                    if (gap_cnt_q >= GAP_LIM) begin
                        in_ready_q <= 1'b1;
                        state_q    <= NEXT;
                    end
                end
                NEXT: begin
                    // Later blocks reuse the configuration frozen at message start.
                    if (in_hs) begin
                        plain_q     <= in_data_i;
                        last_q      <= in_last_i;
                        enable_q    <= 1'b1;
                        in_ready_q  <= 1'b0;
                        run_first_q <= 1'b1;
                        state_q     <= RUN;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready_o       = in_ready_q;
    assign out_valid_o      = out_valid_q;
    assign out_data_o       = out_data_q;
    assign out_last_o       = out_last_q;
    assign core_enable_o    = enable_q;
    assign core_ob_o        = ob_q;
    assign core_sa_o        = sa_q;
    assign core_encrypt_o   = enc_q;
    assign core_som_o       = som_q;
    assign core_iv_o        = iv_q;
    assign core_key0_o      = key0_q;
    assign core_key1_o      = key1_q;
    assign core_plaintext_o = plain_q;
    assign busy_o           = (state_q != IDLE);
    assign blk_cnt_o        = blk_cnt_q;
endmodule

// File: tb/tb_ibr128_msg_sequencer.sv
// Directed bench for ibr128_msg_sequencer with a stub core (ready 5 cycles after Enable rise, text = ~plain).
module tb_ibr128_msg_sequencer;
    localparam logic [127:0] BLK_A = 128'h1234_56ab_cd13_2536_1234_56ab_cd13_2536;
    localparam logic [127:0] EXP_A = 128'hedcb_a954_32ec_dac9_edcb_a954_32ec_dac9;
    localparam logic [127:0] BLK_B = 128'h3456_7891_2351_6610_4309_acdf_ec12_ba22;
    localparam logic [127:0] EXP_B = 128'hcba9_876e_dcae_99ef_bcf6_5320_13ed_45dd;
    localparam logic [127:0] BLK_C = 128'h0000_0000_ffff_ffff_a5a5_a5a5_5a5a_5a5a;
    localparam logic [127:0] EXP_C = 128'hffff_ffff_0000_0000_5a5a_5a5a_a5a5_a5a5;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         cfg_sa = 1'b0, cfg_encrypt = 1'b0;
    logic [1:0]   cfg_som = '0;
    logic [31:0]  cfg_iv = '0;
    logic [63:0]  cfg_key0 = '0, cfg_key1 = '0;
    logic         abort = 1'b0;
    logic         in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
    logic [127:0] in_data = '0;
    logic         in_ready, out_valid, out_last;
    logic [127:0] out_data;
    logic         core_enable, core_ob, core_sa, core_encrypt;
    logic [1:0]   core_som;
    logic [31:0]  core_iv;
    logic [63:0]  core_key0, core_key1;
    logic [127:0] core_plaintext, core_ciphertext;
    logic         core_cipher_ready;
    logic         busy, err;
    logic [15:0]  blk_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    logic stub_never = 1'b0;
    int stub_cnt;

    always #5 clk = ~clk;

    ibr128_msg_sequencer #(.GAP_CYCLES(2), .TIMEOUT_CYCLES(16)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .cfg_sa_i(cfg_sa), .cfg_encrypt_i(cfg_encrypt), .cfg_som_i(cfg_som), .cfg_iv_i(cfg_iv),
        .cfg_key0_i(cfg_key0), .cfg_key1_i(cfg_key1), .abort_i(abort),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data), .in_last_i(in_last),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data), .out_last_o(out_last),
        .core_enable_o(core_enable), .core_ob_o(core_ob), .core_sa_o(core_sa),
        .core_encrypt_o(core_encrypt), .core_som_o(core_som), .core_iv_o(core_iv),
        .core_key0_o(core_key0), .core_key1_o(core_key1), .core_plaintext_o(core_plaintext),
        .core_ciphertext_i(core_ciphertext), .core_cipher_ready_i(core_cipher_ready),
        .busy_o(busy), .blk_cnt_o(blk_cnt), .err_o(err)
    );

    // Stub core: stub_cnt = cycles Enable has already been high before the current one.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)            stub_cnt <= 0;
        else if (!core_enable) stub_cnt <= 0;
        else                   stub_cnt <= stub_cnt + 1;
    end
    assign core_cipher_ready = core_enable && !stub_never && (stub_cnt >= 5);
    assign core_ciphertext   = ~core_plaintext;

    // Message-level monitor: OB must stay low and Enable gaps must be >= 2 cycles.
    logic mon_en = 1'b0;
    int low_run = 0, min_gap = 1000, ob_glitch = 0;
    always @(negedge clk) begin
        if (mon_en && busy) begin
            if (core_ob) ob_glitch++;
            if (!core_enable) low_run++;
            else begin
                if (low_run > 0 && low_run < min_gap) min_gap = low_run;
                low_run = 0;
            end
        end
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge of the first RUN cycle.
    task automatic send_block(input logic [127:0] d, input logic l);
        int t = 0;
        in_valid = 1'b1; in_data = d; in_last = l;
        while (!in_ready && t < 200) begin @(negedge clk); t++; end
        chk("in_rdy_wait", t < 200, 1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 100) begin @(negedge clk); cyc++; end
        chk("out_vld_wait", cyc < 100, 1);
    endtask

    task automatic get_result(output logic [127:0] d, output logic l, output logic [15:0] bc);
        int cyc;
        out_ready = 1'b1;
        wait_out(cyc);
        d = out_data; l = out_last; bc = blk_cnt;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] d;
        logic         l;
        logic [15:0]  bc;
        int           cyc, bad;

        // Reset values while held in reset
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_ob", core_ob, 1);
        chk("rst_enable", core_enable, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_blk_cnt", blk_cnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_core_iv", core_iv, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready_up", in_ready, 1);

        // 1: single-block message
        cfg_sa = 1'b1; cfg_encrypt = 1'b1; cfg_som = 2'd3; cfg_iv = 32'h1111_1111;
        cfg_key0 = 64'h0123_4567_89ab_cdef; cfg_key1 = 64'hfedc_ba98_7654_3210;
        chk("t1_ob_idle", core_ob, 1);
        send_block(BLK_A, 1'b1);
        chk("t1_enable", core_enable, 1);
        chk("t1_ob_low", core_ob, 0);
        chk("t1_in_ready", in_ready, 0);
        chk("t1_som", core_som, 3);
        chk("t1_iv", core_iv, 32'h1111_1111);
        chk("t1_key0", core_key0, 64'h0123_4567_89ab_cdef);
        chk("t1_plain", core_plaintext, BLK_A);
        wait_out(cyc);
        chk("t1_latency", cyc, 6);
        chk("t1_out_data", out_data, EXP_A);
        chk("t1_out_last", out_last, 1);
        chk("t1_blk_cnt", blk_cnt, 1);
        chk("t1_hold_enable", core_enable, 0);
        chk("t1_hold_ob", core_ob, 0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("t1_end_ob", core_ob, 1);
        chk("t1_end_blk_cnt", blk_cnt, 0);
        chk("t1_end_out_valid", out_valid, 0);
        chk("t1_end_busy", busy, 0);

        // 2: two-block message, cfg changed mid-message must not be picked up
        send_block(BLK_A, 1'b0);
        mon_en = 1'b1;
        cfg_som = 2'd0; cfg_iv = 32'h2222_2222; cfg_sa = 1'b0;
        get_result(d, l, bc);
        chk("t2_b0_data", d, EXP_A);
        chk("t2_b0_last", l, 0);
        chk("t2_b0_cnt", bc, 1);
        send_block(BLK_B, 1'b1);
        chk("t2_b1_plain", core_plaintext, BLK_B);
        chk("t2_b1_som", core_som, 3);
        chk("t2_b1_iv", core_iv, 32'h1111_1111);
        chk("t2_b1_sa", core_sa, 1);
        get_result(d, l, bc);
        mon_en = 1'b0;
        chk("t2_b1_data", d, EXP_B);
        chk("t2_b1_last", l, 1);
        chk("t2_b1_cnt", bc, 2);
        chk("t2_ob_glitch", ob_glitch, 0);
        chk("t2_gap_seen", min_gap < 1000, 1);
        chk("t2_gap_ge2", min_gap >= 2, 1);
        chk("t2_end_ob", core_ob, 1);

        // 3: out_ready held low for 10 cycles in HOLD
        send_block(BLK_C, 1'b1);
        chk("t3_new_som", core_som, 0);
        wait_out(cyc);
        chk("t3_out_data", out_data, EXP_C);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_data !== EXP_C || in_ready !== 1'b0 || core_enable !== 1'b0 || out_valid !== 1'b1)
                bad++;
        end
        chk("t3_hold_stable", bad, 0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("t3_released", out_valid, 0);
        chk("t3_idle", busy, 0);

        // 4: abort in RUN cycle 3, then a clean message
        send_block(BLK_A, 1'b1);
        @(negedge clk);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("t4_enable", core_enable, 0);
        chk("t4_ob", core_ob, 1);
        chk("t4_busy", busy, 0);
        chk("t4_out_valid", out_valid, 0);
        chk("t4_blk_cnt", blk_cnt, 0);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) bad++;
        end
        chk("t4_no_output", bad, 0);
        send_block(BLK_B, 1'b1);
        get_result(d, l, bc);
        chk("t4_after_data", d, EXP_B);
        chk("t4_after_last", l, 1);

        // 5: core never answers
        stub_never = 1'b1;
        send_block(BLK_A, 1'b1);
        repeat (15) @(negedge clk);
        chk("t5_enable_c16", core_enable, 1);
        chk("t5_err_c16", err, 0);
        @(negedge clk);
`ifdef IBR128_SEQ_TIMEOUT_EN
        chk("t5_err", err, 1);
        chk("t5_ob", core_ob, 1);
        chk("t5_enable", core_enable, 0);
        chk("t5_busy", busy, 0);
        chk("t5_out_valid", out_valid, 0);
`else
        repeat (40) @(negedge clk);
        chk("t5_enable_hold", core_enable, 1);
        chk("t5_err", err, 0);
        chk("t5_busy", busy, 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("t5_abort_idle", busy, 0);
`endif
        stub_never = 1'b0;

        // 6: asynchronous reset mid-RUN
        send_block(BLK_A, 1'b1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t6_enable", core_enable, 0);
        chk("t6_ob", core_ob, 1);
        chk("t6_in_ready", in_ready, 0);
        chk("t6_busy", busy, 0);
        chk("t6_plain", core_plaintext, 0);
        chk("t6_iv", core_iv, 0);
        chk("t6_err", err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_block(BLK_B, 1'b1);
        get_result(d, l, bc);
        chk("t6_after_data", d, EXP_B);
        chk("t6_after_cnt", bc, 1);
        chk("t6_after_busy", busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
